// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/status controller for a fifo_reg_file FIFO.
// Define FIFO_CTRL_ERR_EN to build the sticky overflow/underflow flags.
module fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned AF_LEVEL   = 3,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic                  flush_i,
  input  logic                  err_clr_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic [ADDR_WIDTH-1:0] r_addr_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] PTR_INC = PW'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = PW'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = PW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_L    = PW'(AE_LEVEL);

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] level;
  logic                push_ok;
  logic                pop_ok;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign level_o  = level;
  assign w_addr_o = wr_ptr_q[ADDR_WIDTH-1:0];
  assign r_addr_o = rd_ptr_q[ADDR_WIDTH-1:0];

  assign full_o         = (level == DEPTH_L);
  assign empty_o        = (level == '0);
  assign almost_full_o  = (level >= AF_L);
  assign almost_empty_o = (level <= AE_L);

  // A pop frees the slot being overwritten, so push is legal when full
  assign push_ok = wr_i & (~full_o | rd_i);
  assign pop_ok  = rd_i & ~empty_o;
  assign wr_en_o = push_ok & ~flush_i & rst_ni;

  // Pointer next-state: flush beats any request
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_INC;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_INC;
    end
  end

  // Pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
  logic ovf_set;
  logic udf_set;

  assign ovf_set = wr_i & ~push_ok & ~flush_i;
  assign udf_set = rd_i & ~pop_ok & ~flush_i;

  // Sticky error next-state: a new error wins over clear
  always_comb begin
    ovf_d = (ovf_q & ~err_clr_i) | ovf_set;
    udf_d = (udf_q & ~err_clr_i) | udf_set;
  end

  // Error registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr_i;
  assign overflow_o     = 1'b0;
  assign underflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed scoreboard bench for fifo_ctrl (depth 4).
// Expected outputs are queued per cycle and checked by a monitor.
module tb_fifo_ctrl;

`ifdef FIFO_CTRL_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] v;
    logic        chk;
    logic [7:0]  rdat;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       wr_i = 1'b0;
  logic       rd_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic       wr_en_o;
  logic [1:0] w_addr_o;
  logic [1:0] r_addr_o;
  logic       full_o;
  logic       empty_o;
  logic       almost_full_o;
  logic       almost_empty_o;
  logic [2:0] level_o;
  logic       overflow_o;
  logic       underflow_o;

  logic [7:0] mem [4];
  logic [7:0] wcnt = 8'd0;

  exp_t  exp_q [$];
  string nm_q [$];
  int    n_tests = 0;
  int    n_fail = 0;

  fifo_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wr_i           (wr_i),
    .rd_i           (rd_i),
    .flush_i        (flush_i),
    .err_clr_i      (err_clr_i),
    .wr_en_o        (wr_en_o),
    .w_addr_o       (w_addr_o),
    .r_addr_o       (r_addr_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .level_o        (level_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Register file model: push order numbers written on wr_en_o
  always @(posedge clk_i) begin
    if (wr_en_o) begin
      mem[w_addr_o] <= wcnt;
      wcnt <= wcnt + 8'd1;
    end
  end

  // Monitor: compare outputs mid-cycle against queued expectations
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      logic [15:0] got;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      got = {wr_en_o, w_addr_o, r_addr_o, level_o, full_o, empty_o,
             almost_full_o, almost_empty_o, overflow_o, underflow_o,
             2'b00};
      n_tests++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", n, got, e.v);
      end
      if (e.chk) begin
        n_tests++;
        if (mem[r_addr_o] !== e.rdat) begin
          n_fail++;
          $display("FAIL %s data: got %0d want %0d",
                   n, mem[r_addr_o], e.rdat);
        end
      end
    end
  end

  task automatic cyc(input string nm, input bit rstn, input bit wr,
                     input bit rd, input bit fl, input bit clr,
                     input bit wen, input int wa, input int ra,
                     input int lvl, input bit ov, input bit ud,
                     input int rdat);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_ni    = rstn;
    wr_i      = wr;
    rd_i      = rd;
    flush_i   = fl;
    err_clr_i = clr;
    e.v = {wen, 2'(wa), 2'(ra), 3'(lvl), lvl == 4, lvl == 0,
           lvl >= 3, lvl <= 1, ov & ERR, ud & ERR, 2'b00};
    e.chk  = (rdat >= 0);
    e.rdat = 8'(rdat);
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  initial begin
    //   name        rn wr rd fl cl wen wa ra lv ov ud rdat
    cyc("reset",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    cyc("push0",     1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, -1);
    cyc("push1",     1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, -1);
    cyc("push2",     1, 1, 0, 0, 0, 1, 2, 0, 2, 0, 0, -1);
    cyc("push3",     1, 1, 0, 0, 0, 1, 3, 0, 3, 0, 0, -1);
    cyc("ovf_push",  1, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0, -1);
    cyc("ovf_clr",   1, 0, 0, 0, 1, 0, 0, 0, 4, 1, 0, -1);
    cyc("ovf_gone",  1, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, -1);
    cyc("pp0",       1, 1, 1, 0, 0, 1, 0, 0, 4, 0, 0, 0);
    cyc("pp1",       1, 1, 1, 0, 0, 1, 1, 1, 4, 0, 0, 1);
    cyc("pp2",       1, 1, 1, 0, 0, 1, 2, 2, 4, 0, 0, 2);
    cyc("pp3",       1, 1, 1, 0, 0, 1, 3, 3, 4, 0, 0, 3);
    cyc("pp4",       1, 1, 1, 0, 0, 1, 0, 0, 4, 0, 0, 4);
    cyc("pp5",       1, 1, 1, 0, 0, 1, 1, 1, 4, 0, 0, 5);
    cyc("pop0",      1, 0, 1, 0, 0, 0, 2, 2, 4, 0, 0, 6);
    cyc("pop1",      1, 0, 1, 0, 0, 0, 2, 3, 3, 0, 0, 7);
    cyc("pop2",      1, 0, 1, 0, 0, 0, 2, 0, 2, 0, 0, 8);
    cyc("pop3",      1, 0, 1, 0, 0, 0, 2, 1, 1, 0, 0, 9);
    cyc("empty_pp",  1, 1, 1, 0, 0, 1, 2, 2, 0, 0, 0, -1);
    cyc("udf_seen",  1, 0, 0, 0, 0, 0, 3, 2, 1, 0, 1, 10);
    cyc("udf_clr",   1, 0, 0, 0, 1, 0, 3, 2, 1, 0, 1, -1);
    cyc("fill_a",    1, 1, 0, 0, 0, 1, 3, 2, 1, 0, 0, -1);
    cyc("fill_b",    1, 1, 0, 0, 0, 1, 0, 2, 2, 0, 0, -1);
    cyc("flush_wr",  1, 1, 0, 1, 0, 0, 1, 2, 3, 0, 0, -1);
    cyc("post_fl",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    cyc("udf_pop",   1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    cyc("udf_set",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, -1);
    cyc("set_win",   1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, -1);
    cyc("set_held",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, -1);
    cyc("clr2",      1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, -1);
    cyc("clr2_done", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    cyc("mid_p0",    1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, -1);
    cyc("mid_p1",    1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, -1);
    cyc("mid_l2",    1, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, -1);
    cyc("async_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    cyc("after_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
        @(posedge clk_i);
        budget++;
      end
      if (exp_q.size() > 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
